limn2600_cache_ctrl: RTL and testbench

Direct-mapped cache controller between the Limn2600 load/store unit and the cache data array. It holds tags and valid bits, drives the array's address, write-enable and write-data ports, and runs line fills from the memory bus on read misses. Writes are write-through and no-write-allocate. Lines can be bulk-invalidated with a flush input.

---
 rtl/limn2600_cache_pkg.sv | 38 +++
 rtl/limn2600_cache_tags.sv | 51 +++++
 rtl/limn2600_cache_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_limn2600_cache_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/limn2600_cache_pkg.sv
`default_nettype none
// ============================================================================
// limn2600_cache_pkg : shared types and address-slice constants for the
//                      Limn2600 direct-mapped cache controller.
// Revision: 1.0
// ============================================================================
package limn2600_cache_pkg;

  localparam int C_INDEX_BITS = 4;
  localparam int C_WORD_BITS  = 3;
  localparam int C_TAG_BITS   = 32 - C_INDEX_BITS - C_WORD_BITS - 2;
  localparam int C_WORD_LSB   = 2;
  localparam int C_INDEX_LSB  = C_WORD_LSB + C_WORD_BITS;
  localparam int C_TAG_LSB    = C_INDEX_LSB + C_INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    WRITE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [C_TAG_BITS-1:0]   tag;
    logic [C_INDEX_BITS-1:0] index;
    logic [C_WORD_BITS-1:0]  word;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [31:0] addr);
    addr_split_t s;
    s.tag   = addr[31:C_TAG_LSB];
    s.index = addr[C_TAG_LSB-1:C_INDEX_LSB];
    s.word  = addr[C_INDEX_LSB-1:C_WORD_LSB];
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/limn2600_cache_tags.sv
`default_nettype none
// ============================================================================
// limn2600_cache_tags : tag RAM with per-line valid bits, combinational read,
//                       single write port and one-cycle clear-all.
// Revision: 1.0
// ============================================================================
module limn2600_cache_tags
  import limn2600_cache_pkg::*;
#(
  parameter int INDEX_BITS = C_INDEX_BITS,
  parameter int TAG_BITS   = C_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic                  i_wr_valid,
  input  logic [TAG_BITS-1:0]   i_wr_tag
);

  localparam int C_LINES = 1 << INDEX_BITS;

  logic [C_LINES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag_ram [C_LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= i_wr_valid;
    end
  end

  // Tags need no reset: a tag is only trusted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag_ram[i_wr_index] <= i_wr_tag;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag_ram[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/limn2600_cache_ctrl.sv
`default_nettype none
// ============================================================================
// limn2600_cache_ctrl : direct-mapped, write-through, no-write-allocate cache
//                       controller with line fill from the memory bus.
// Revision: 1.0
// ============================================================================
module limn2600_cache_ctrl
  import limn2600_cache_pkg::*;
#(
  parameter int INDEX_BITS = C_INDEX_BITS,
  parameter int WORD_BITS  = C_WORD_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          cpu_valid,
  output logic                          cpu_ready,
  input  logic [31:0]                   cpu_addr,
  input  logic                          cpu_we,
  input  logic [31:0]                   cpu_wdata,
  output logic                          cpu_done,
  output logic [31:0]                   cpu_rdata,
  output logic [INDEX_BITS+WORD_BITS-1:0] arr_addr,
  output logic                          arr_we,
  output logic [31:0]                   arr_wdata,
  input  logic [31:0]                   arr_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata
);

  localparam int TAG_BITS    = 32 - INDEX_BITS - WORD_BITS - 2;
  localparam int C_INDEX_LSB = 2 + WORD_BITS;
  localparam int C_TAG_LSB   = C_INDEX_LSB + INDEX_BITS;
  localparam logic [WORD_BITS-1:0] C_LAST_WORD = '1;

  state_t                r_state;
  logic [TAG_BITS-1:0]   r_tag;
  logic [INDEX_BITS-1:0] r_index;
  logic [WORD_BITS-1:0]  r_word;
  logic [WORD_BITS-1:0]  r_cnt;
  logic                  r_we;
  logic                  r_hit;
  logic [31:0]           r_wdata;

  logic                  w_ack;
  logic                  w_accept;
  logic                  w_clear;
  logic                  w_hit;
  logic                  w_line_valid;
  logic [TAG_BITS-1:0]   w_line_tag;
  logic                  w_tag_we;
  logic                  w_tag_valid;
  logic [WORD_BITS-1:0]  w_cnt_next;
  logic                  w_unused;

  assign w_ack      = mem_ack && mem_req;
  assign w_clear    = (r_state == IDLE) && flush;
  assign cpu_ready  = (r_state == IDLE) && !flush;
  assign w_accept   = cpu_valid && cpu_ready;
  assign w_hit      = w_line_valid && (w_line_tag == r_tag);
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_unused   = &{1'b0, cpu_addr[1:0]};

  // A miss invalidates the line up front so it is never half-filled and valid.
  assign w_tag_we    = ((r_state == LOOKUP) && !r_we && !w_hit) ||
                       ((r_state == FILL) && w_ack && (r_cnt == C_LAST_WORD));
  assign w_tag_valid = (r_state == FILL);

  limn2600_cache_tags #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_rd_index (r_index),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .i_wr_en    (w_tag_we),
    .i_wr_index (r_index),
    .i_wr_valid (w_tag_valid),
    .i_wr_tag   (r_tag)
  );

  always_comb begin
    arr_addr  = cpu_addr[C_TAG_LSB-1:2];
    arr_we    = 1'b0;
    arr_wdata = r_wdata;
    case (r_state)
      LOOKUP: arr_addr = {r_index, r_word};
      FILL: begin
        arr_addr  = {r_index, r_cnt};
        arr_we    = w_ack;
        arr_wdata = mem_rdata;
      end
      WRITE: begin
        arr_addr = {r_index, r_word};
        arr_we   = w_ack && r_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tag     <= '0;
      r_index   <= '0;
      r_word    <= '0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_hit     <= 1'b0;
      r_wdata   <= '0;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tag   <= cpu_addr[31:C_TAG_LSB];
            r_index <= cpu_addr[C_TAG_LSB-1:C_INDEX_LSB];
            r_word  <= cpu_addr[C_INDEX_LSB-1:2];
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (r_we) begin
            r_hit     <= w_hit;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {r_tag, r_index, r_word, 2'b00};
            mem_wdata <= r_wdata;
            r_state   <= WRITE;
          end else if (w_hit) begin
            cpu_rdata <= arr_rdata;
            cpu_done  <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt    <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {r_tag, r_index, {WORD_BITS{1'b0}}, 2'b00};
            r_state  <= FILL;
          end
        end
        FILL: begin
          if (w_ack) begin
            if (r_cnt == r_word) begin
              cpu_rdata <= mem_rdata;
            end
            if (r_cnt == C_LAST_WORD) begin
              mem_req  <= 1'b0;
              cpu_done <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_cnt    <= w_cnt_next;
              mem_addr <= {r_tag, r_index, w_cnt_next, 2'b00};
            end
          end
        end
        WRITE: begin
          if (w_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_limn2600_cache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_limn2600_cache_ctrl : bench for limn2600_cache_ctrl with a bus/array
//                          model and a memory-level reference of the cache.
// Revision: 1.0
// ============================================================================
module tb_limn2600_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [31:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic [6:0]  arr_addr;
  logic        arr_we;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  limn2600_cache_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .arr_addr(arr_addr), .arr_we(arr_we), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct packed { logic [6:0] a; logic [31:0] d; } arr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [31:0] done_rdata = '0;
  bus_t bus_q[$];
  arr_t arr_q[$];
  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] aram [0:127];
  int dly = 0;
  bit slow_bus = 0;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return mem_default(a);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return mem_default(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Registered cache data array.
  always @(posedge clk) begin
    if (arr_we) aram[arr_addr] <= arr_wdata;
    arr_rdata <= aram[arr_addr];
  end

  // Memory bus responder with a random 0..2 cycle wait per request.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mem_ack = 1'b0;
      dly = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (dly > 0) begin
        dly = dly - 1;
      end else begin
        mem_ack = 1'b1;
        if (mem_we) begin
          bmem[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
          bus_q.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = bus_read(mem_addr);
          bus_q.push_back({1'b0, mem_addr, mem_rdata});
        end
        dly = slow_bus ? 3 : int'($urandom_range(0, 2));
      end
    end
  end

  always @(negedge clk) begin
    if (arr_we) arr_q.push_back({arr_addr, arr_wdata});
    if (cpu_done) begin
      done_cnt = done_cnt + 1;
      done_rdata = cpu_rdata;
      done_cyc = cyc;
    end
  end

  task automatic issue_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           output int c_before);
    int n;
    bus_q.delete();
    arr_q.delete();
    done_cnt = 0;
    @(negedge clk);
    cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_valid = 1'b1;
    n = 0;
    while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
    c_before = cyc;
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  task automatic wait_done(input int c_before, output logic [31:0] rd, output int lat);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin @(posedge clk); n++; end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: no cpu_done within %0d cycles", n);
    end
    rd = done_rdata;
    lat = done_cyc - c_before;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
    int c;
    issue_req(a, we, wd, c);
    wait_done(c, rd, lat);
  endtask

  task automatic check_fill(input string nm, input logic [31:0] base, input logic [31:0] rd,
                            input logic [31:0] want);
    total++;
    if (rd !== want) begin bad++; $display("FAIL %s_rdata got=%h want=%h", nm, rd, want); end
    total++;
    if (bus_q.size() != 8) begin bad++; $display("FAIL %s_nreads got=%0d want=8", nm, bus_q.size()); end
    for (int n = 0; n < bus_q.size() && n < 8; n++) begin
      total++;
      if (bus_q[n].we !== 1'b0 || bus_q[n].addr !== base + 32'(4 * n)) begin
        bad++;
        $display("FAIL %s_read%0d got we=%b addr=%h want we=0 addr=%h", nm, n,
                 bus_q[n].we, bus_q[n].addr, base + 32'(4 * n));
      end
    end
    total++;
    if (arr_q.size() != 8) begin bad++; $display("FAIL %s_arr_writes got=%0d want=8", nm, arr_q.size()); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL %s_done_count got=%0d want=1", nm, done_cnt); end
  endtask

  task automatic test_reset();
    total++;
    if (cpu_ready !== 1'b1 || cpu_done !== 1'b0 || cpu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_cpu got ready=%b done=%b rdata=%h want 1 0 0", cpu_ready, cpu_done, cpu_rdata);
    end
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || arr_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus got req=%b we=%b addr=%h arr_we=%b want 0 0 0 0",
               mem_req, mem_we, mem_addr, arr_we);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cpu_ready !== 1'b1 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got ready=%b req=%b want 1 0", cpu_ready, mem_req);
    end
  endtask

  task automatic test_fill_miss();
    logic [31:0] rd; int lat;
    do_access(32'h0000_1044, 1'b0, 32'h0, rd, lat);
    check_fill("miss1044", 32'h0000_1040, rd, 32'h0000_00A1);
    total++;
    if (arr_q.size() == 8 && (arr_q[3].a !== 7'h13 || arr_q[3].d !== 32'hA3)) begin
      bad++;
      $display("FAIL miss1044_arr3 got a=%h d=%h want a=13 d=000000a3", arr_q[3].a, arr_q[3].d);
    end
  endtask

  task automatic test_hit();
    logic [31:0] rd; int lat;
    do_access(32'h0000_1044, 1'b0, 32'h0, rd, lat);
    total++;
    if (rd !== 32'hA1) begin bad++; $display("FAIL hit_rdata got=%h want=000000a1", rd); end
    total++;
    if (bus_q.size() != 0) begin bad++; $display("FAIL hit_bus got=%0d want=0", bus_q.size()); end
    total++;
    if (lat != 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", lat); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL hit_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_store();
    logic [31:0] rd; int lat;
    exp_mem[32'h1048] = 32'hDEAD_BEEF;
    do_access(32'h0000_1048, 1'b1, 32'hDEAD_BEEF, rd, lat);
    total++;
    if (bus_q.size() != 1 || bus_q[0] !== {1'b1, 32'h1048, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL store_hit_bus got n=%0d want one write 1048=deadbeef", bus_q.size());
    end
    total++;
    if (arr_q.size() != 1 || arr_q[0] !== {7'h12, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL store_hit_arr got n=%0d want one write at 12", arr_q.size());
    end
    do_access(32'h0000_1048, 1'b0, 32'h0, rd, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF || bus_q.size() != 0) begin
      bad++;
      $display("FAIL store_readback got=%h bus=%0d want=deadbeef bus=0", rd, bus_q.size());
    end
    exp_mem[32'h2000] = 32'h1234_5678;
    do_access(32'h0000_2000, 1'b1, 32'h1234_5678, rd, lat);
    total++;
    if (bus_q.size() != 1 || bus_q[0] !== {1'b1, 32'h2000, 32'h1234_5678}) begin
      bad++;
      $display("FAIL store_miss_bus got n=%0d want one write 2000=12345678", bus_q.size());
    end
    total++;
    if (arr_q.size() != 0) begin bad++; $display("FAIL store_miss_arr got=%0d want=0", arr_q.size()); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; int lat;
    do_access(32'h0000_3044, 1'b0, 32'h0, rd, lat);
    check_fill("conf3044", 32'h0000_3040, rd, model_word(32'h3044));
    do_access(32'h0000_1044, 1'b0, 32'h0, rd, lat);
    check_fill("conf1044", 32'h0000_1040, rd, 32'h0000_00A1);
  endtask

  task automatic test_flush();
    logic [31:0] rd; int lat;
    bus_q.delete(); arr_q.delete(); done_cnt = 0;
    @(negedge clk);
    flush = 1'b1; cpu_valid = 1'b1; cpu_addr = 32'h1044; cpu_we = 1'b0;
    #1;
    total++;
    if (cpu_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", cpu_ready); end
    @(negedge clk);
    flush = 1'b0; cpu_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt != 0 || bus_q.size() != 0) begin
      bad++;
      $display("FAIL flush_not_accepted got done=%0d bus=%0d want 0 0", done_cnt, bus_q.size());
    end
    do_access(32'h0000_1044, 1'b0, 32'h0, rd, lat);
    check_fill("flush1044", 32'h0000_1040, rd, 32'h0000_00A1);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; int lat; int c; int n;
    slow_bus = 1;
    issue_req(32'h0000_5044, 1'b0, 32'h0, c);
    n = 0;
    while (!(bus_q.size() == 3 && mem_req && mem_addr == 32'h504C) && n < 200) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= 200) begin bad++; $display("FAIL abort_reach_word3 got reads=%0d want=3", bus_q.size()); end
    rst = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || cpu_done !== 1'b0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL abort_reset got req=%b ready=%b done=%b addr=%h want 0 1 0 0",
               mem_req, cpu_ready, cpu_done, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    slow_bus = 0;
    repeat (10) @(negedge clk);
    total++;
    if (done_cnt != 0 || cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_after got done=%0d ready=%b want 0 1", done_cnt, cpu_ready);
    end
    do_access(32'h0000_1044, 1'b0, 32'h0, rd, lat);
    check_fill("abort1044", 32'h0000_1040, rd, 32'h0000_00A1);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_random();
    bit mv[16];
    int mt[16];
    logic [31:0] a, wa, wd, rd;
    int tg, idx, w, lat;
    bit hit, we;
    do_flush();
    for (int i = 0; i < 16; i++) mv[i] = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_flush();
        for (int j = 0; j < 16; j++) mv[j] = 0;
      end
      tg  = 2 * int'($urandom_range(0, 3)) + 1;
      idx = int'($urandom_range(0, 3));
      w   = int'($urandom_range(0, 7));
      a   = 32'((tg << 9) | (idx << 5) | (w << 2)) | 32'($urandom_range(0, 3));
      wa  = a & ~32'h3;
      hit = mv[idx] && mt[idx] == tg;
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if (we) exp_mem[wa] = wd;
      do_access(a, we, wd, rd, lat);
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL rnd%0d_done got=%0d want=1", i, done_cnt); end
      if (we) begin
        total++;
        if (bus_q.size() != 1 || bus_q[0] !== {1'b1, wa, wd}) begin
          bad++;
          $display("FAIL rnd%0d_store_bus got n=%0d want write %h=%h", i, bus_q.size(), wa, wd);
        end
        total++;
        if (arr_q.size() != (hit ? 1 : 0)) begin
          bad++;
          $display("FAIL rnd%0d_store_arr got=%0d want=%0d", i, arr_q.size(), hit ? 1 : 0);
        end
      end else begin
        total++;
        if (rd !== model_word(wa)) begin
          bad++;
          $display("FAIL rnd%0d_load got=%h want=%h addr=%h", i, rd, model_word(wa), a);
        end
        total++;
        if (bus_q.size() != (hit ? 0 : 8)) begin
          bad++;
          $display("FAIL rnd%0d_load_bus got=%0d want=%0d", i, bus_q.size(), hit ? 0 : 8);
        end
        if (hit) begin
          total++;
          if (lat != 2) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=2", i, lat); end
        end else begin
          mv[idx] = 1;
          mt[idx] = tg;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 8; n++) begin
      bmem[32'h1040 + 32'(4 * n)]    = 32'hA0 + 32'(n);
      exp_mem[32'h1040 + 32'(4 * n)] = 32'hA0 + 32'(n);
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_fill_miss();
    test_hit();
    test_store();
    test_conflict();
    test_flush();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
